ejtag_lbc_arbiter: RTL
======================

Name: ejtag_lbc_arbiter

Overview:
- Sequences and shares the local-bus master port between two requesters: the EJTAG DMA engine (probe-initiated accesses) and a core-side debug requester (CPU).
- Sits between the EJTAG control/DMA-data logic and the local bus controller.
- Grants one requester per transaction, drives the bus request until acknowledge or timeout, and returns read data with a done/error pulse to the owner.
- Sizes and alignment are checked before any bus cycle is issued.

Parameters:
- TIMEOUT_CYCLES, 255: cycles in BUSY without LBC_ACK before the transaction is aborted. Legal range 1..255.
- STARVE_LIMIT, 4: consecutive arbitrations CPU may lose to DMA before CPU is forced to win. Legal range 1..15.

Ports:
- CORE_CLOCK  in  1  single clock; all state updates on the rising edge.
- RESET_D1_R  in  1  synchronous, active-high reset.
- EJ_DMAREQ  in  1  DMA request; level, held until EJ_DMADONE or EJ_DMAERR.
- EJ_DMARW  in  1  1 = read, 0 = write.
- EJ_DMASZ  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- EJDD_ADDR  in  32  DMA address.
- EJDD_DATA  in  32  DMA write data.
- CPU_REQ  in  1  CPU request; same rules as EJ_DMAREQ.
- CPU_RW  in  1  CPU read/write.
- CPU_SZ  in  2  CPU size.
- CPU_ADDR  in  32  CPU address.
- CPU_WDATA  in  32  CPU write data.
- LBC_ACK  in  1  bus transaction complete.
- LBC_ERR  in  1  bus error; qualified by LBC_ACK.
- LBC_RDATA  in  32  read data; valid with LBC_ACK.
- BUS_REQ  out  1  bus request.
- BUS_RW  out  1  read/write to bus.
- BUS_SZ  out  2  size to bus.
- BUS_ADDR  out  32  address to bus.
- BUS_WDATA  out  32  write data to bus.
- BUS_OWNER_R  out  1  0 = DMA, 1 = CPU; valid while not IDLE.
- EJ_DMADONE  out  1  one-cycle done pulse to DMA.
- EJ_DMAERR  out  1  one-cycle error pulse to DMA.
- CPU_ACK  out  1  one-cycle done pulse to CPU.
- CPU_ERR  out  1  one-cycle error pulse to CPU.
- RDATA_R  out  32  captured read data, shared by both requesters.

Behaviour:
- Reset:
  - All outputs 0, RDATA_R = 0.
  - State = IDLE; starve counter and timeout counter cleared.
  - Reset mid-transaction drops BUS_REQ on the next edge with no done/error pulse.
- States: IDLE, BUSY, DONE, ERR.
- IDLE:
  - Requests are sampled only in IDLE.
  - If only one requester is active, it wins.
  - If both are active, DMA wins unless starve count = STARVE_LIMIT, in which case CPU wins.
  - Starve counter: increments each time CPU loses; clears when CPU wins or CPU_REQ = 0.
- Winner's command is latched into BUS_RW/BUS_SZ/BUS_ADDR/BUS_WDATA and BUS_OWNER_R.
- Illegal command (SZ = 11, half with ADDR[0] = 1, or word with ADDR[1:0] != 00):
  - Goes IDLE -> ERR with no BUS_REQ.
- Legal command:
  - Goes IDLE -> BUSY; BUS_REQ = 1 in the first BUSY cycle (one-cycle latency from request sampled).
- BUSY:
  - BUS_REQ and all command outputs are held stable.
  - Timeout counter increments each cycle.
  - LBC_ACK = 1 and LBC_ERR = 0: go to DONE. On a read, RDATA_R <= LBC_RDATA; on a write, RDATA_R is unchanged.
  - LBC_ACK = 1 and LBC_ERR = 1: go to ERR. On a read, RDATA_R is still captured.
  - Counter reaches TIMEOUT_CYCLES without ack: go to ERR; BUS_REQ drops.
  - LBC_ACK on the same cycle as timeout: the ack wins.
- DONE and ERR:
  - Each lasts exactly one cycle with BUS_REQ = 0.
  - DONE pulses EJ_DMADONE or CPU_ACK for the owner.
  - ERR pulses EJ_DMAERR or CPU_ERR for the owner.
  - Then returns to IDLE.
- Requester rule: deassert REQ at the edge ending the DONE/ERR cycle, so the next IDLE cycle sees REQ = 0.
  - Back-to-back transactions from one requester are therefore separated by at least one IDLE cycle.
- A requester dropping REQ in BUSY is ignored; the transaction completes.
- LBC_ACK outside BUSY is ignored.
- Timeout counter clears on entry to BUSY.
- Starve counter saturates at STARVE_LIMIT.

Decomposition:
- Shared package (lxr_symbols or an EJTAG package) holds:
  - state encodings;
  - size codes (SZ_BYTE = 00, SZ_HALF = 01, SZ_WORD = 10);
  - owner codes (OWN_DMA = 0, OWN_CPU = 1);
  - an alignment-check function.
- One natural sub-module: ejtag_lbc_arbiter_pick, the combinational priority/starvation selection plus starve-counter update.
- FSM, timeout counter and data capture stay in the top module.

Test Plan:
1. DMA word read @0x0000_1000 alone; LBC_ACK after 3 cycles with RDATA 0xDEAD_BEEF -> BUS_REQ for 3 cycles, EJ_DMADONE single pulse, RDATA_R = 0xDEAD_BEEF, CPU_ACK never asserts.
2. DMA and CPU both requesting continuously, STARVE_LIMIT = 4, 1-cycle acks -> grant order DMA, DMA, DMA, DMA, CPU, then repeats; BUS_OWNER_R matches.
3. CPU half write to 0x0000_0003 -> no BUS_REQ, CPU_ERR pulse 1 cycle after sampling; SZ = 11 gives the same response.
4. DMA read with LBC_ACK withheld, TIMEOUT_CYCLES = 8 -> BUS_REQ high 8 cycles then low, EJ_DMAERR pulse. Repeat with ack on cycle 8 -> EJ_DMADONE instead.
5. LBC_ACK = 1 and LBC_ERR = 1 on a CPU read of 0x1234_5678 -> CPU_ERR pulse, RDATA_R = 0x1234_5678.
6. RESET_D1_R asserted mid-BUSY -> next edge: BUS_REQ = 0, all pulses 0, state IDLE; a new request afterwards is granted normally.

Source files
------------

// File: rtl/ejtag_lbc_arbiter_pkg.sv
// Shared symbols for the EJTAG / core-debug local-bus arbiter.
package ejtag_lbc_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10,
        ST_ERR  = 2'b11
    } arb_state_t;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    localparam logic OWN_DMA = 1'b0;
    localparam logic OWN_CPU = 1'b1;

    localparam int STARVE_W = 4;
    localparam int TMO_W    = 8;

    // A command may go to the bus only if its size code exists and the
    // address is naturally aligned for that size.
    function automatic logic cmd_legal(input logic [1:0] sz, input logic [1:0] addr_lo);
        logic ok;
        case (sz)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~addr_lo[0];
            SZ_WORD: ok = (addr_lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ejtag_lbc_arbiter_pick.sv
// Priority selection between DMA and CPU with CPU starvation protection.
module ejtag_lbc_arbiter_pick
    import ejtag_lbc_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                dma_req,
    input  logic                cpu_req,
    input  logic [STARVE_W-1:0] starve_cnt,
    output logic                grant_valid,
    output logic                grant_own,
    output logic [STARVE_W-1:0] starve_nxt
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    // DMA normally wins; CPU wins when alone or once it has lost LIMIT times in a row.
    always_comb begin
        grant_valid = dma_req | cpu_req;
        grant_own   = OWN_DMA;
        starve_nxt  = starve_cnt;
        if (!cpu_req) begin
            starve_nxt = '0;
        end else if (!dma_req || (starve_cnt == LIMIT)) begin
            grant_own  = OWN_CPU;
            starve_nxt = '0;
        end else if (starve_cnt < LIMIT) begin
            starve_nxt = starve_cnt + STARVE_W'(1);
        end
    end

endmodule

// File: rtl/ejtag_lbc_arbiter.sv
// Local-bus master arbiter shared by the EJTAG DMA engine and the core debug requester.
//
//   state | meaning
//   IDLE  | sample requests, pick owner, latch its command
//   BUSY  | BUS_REQ held until LBC_ACK or timeout
//   DONE  | one-cycle done pulse to owner
//   ERR   | one-cycle error pulse to owner (bad command, bus error, timeout)
module ejtag_lbc_arbiter
    import ejtag_lbc_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic        CORE_CLOCK,
    input  logic        RESET_D1_R,
    input  logic        EJ_DMAREQ,
    input  logic        EJ_DMARW,
    input  logic [1:0]  EJ_DMASZ,
    input  logic [31:0] EJDD_ADDR,
    input  logic [31:0] EJDD_DATA,
    input  logic        CPU_REQ,
    input  logic        CPU_RW,
    input  logic [1:0]  CPU_SZ,
    input  logic [31:0] CPU_ADDR,
    input  logic [31:0] CPU_WDATA,
    input  logic        LBC_ACK,
    input  logic        LBC_ERR,
    input  logic [31:0] LBC_RDATA,
    output logic        BUS_REQ,
    output logic        BUS_RW,
    output logic [1:0]  BUS_SZ,
    output logic [31:0] BUS_ADDR,
    output logic [31:0] BUS_WDATA,
    output logic        BUS_OWNER_R,
    output logic        EJ_DMADONE,
    output logic        EJ_DMAERR,
    output logic        CPU_ACK,
    output logic        CPU_ERR,
    output logic [31:0] RDATA_R
);

    // Last BUSY cycle index; the counter starts at 0 in the first BUSY cycle.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    arb_state_t          state;
    arb_state_t          state_nxt;
    logic [STARVE_W-1:0] starve_cnt;
    logic [STARVE_W-1:0] starve_nxt;
    logic [TMO_W-1:0]    tmo_cnt;
    logic                grant_valid;
    logic                grant_own;
    logic                sel_rw;
    logic [1:0]          sel_sz;
    logic [31:0]         sel_addr;
    logic [31:0]         sel_wdata;
    logic                cmd_ok;

    ejtag_lbc_arbiter_pick #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_pick (
        .dma_req    (EJ_DMAREQ),
        .cpu_req    (CPU_REQ),
        .starve_cnt (starve_cnt),
        .grant_valid(grant_valid),
        .grant_own  (grant_own),
        .starve_nxt (starve_nxt)
    );

    // Route the winning requester's command and check it before any bus cycle.
    always_comb begin
        sel_rw    = EJ_DMARW;
        sel_sz    = EJ_DMASZ;
        sel_addr  = EJDD_ADDR;
        sel_wdata = EJDD_DATA;
        if (grant_own == OWN_CPU) begin
            sel_rw    = CPU_RW;
            sel_sz    = CPU_SZ;
            sel_addr  = CPU_ADDR;
            sel_wdata = CPU_WDATA;
        end
        cmd_ok = cmd_legal(sel_sz, sel_addr[1:0]);
    end

    // State register.
    always_ff @(posedge CORE_CLOCK) begin
        if (RESET_D1_R) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; an ack in the timeout cycle still completes normally.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (grant_valid) begin
                    state_nxt = cmd_ok ? ST_BUSY : ST_ERR;
                end
            end
            ST_BUSY: begin
                if (LBC_ACK) begin
                    state_nxt = LBC_ERR ? ST_ERR : ST_DONE;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_nxt = ST_ERR;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            ST_ERR:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Latch the winner's command at grant; it stays stable through BUSY.
    always_ff @(posedge CORE_CLOCK) begin
        if (RESET_D1_R) begin
            BUS_RW      <= 1'b0;
            BUS_SZ      <= SZ_BYTE;
            BUS_ADDR    <= '0;
            BUS_WDATA   <= '0;
            BUS_OWNER_R <= OWN_DMA;
        end else if ((state == ST_IDLE) && grant_valid) begin
            BUS_RW      <= sel_rw;
            BUS_SZ      <= sel_sz;
            BUS_ADDR    <= sel_addr;
            BUS_WDATA   <= sel_wdata;
            BUS_OWNER_R <= grant_own;
        end
    end

    // Starvation counter only moves on arbitration decisions made in IDLE.
    always_ff @(posedge CORE_CLOCK) begin
        if (RESET_D1_R) begin
            starve_cnt <= '0;
        end else if (state == ST_IDLE) begin
            starve_cnt <= starve_nxt;
        end
    end

    // Timeout counter runs only in BUSY, so it is zero on every BUSY entry.
    always_ff @(posedge CORE_CLOCK) begin
        if (RESET_D1_R) begin
            tmo_cnt <= '0;
        end else if (state == ST_BUSY) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end else begin
            tmo_cnt <= '0;
        end
    end

    // Capture read data on any ack, including an error ack.
    always_ff @(posedge CORE_CLOCK) begin
        if (RESET_D1_R) begin
            RDATA_R <= '0;
        end else if ((state == ST_BUSY) && LBC_ACK && BUS_RW) begin
            RDATA_R <= LBC_RDATA;
        end
    end

    assign BUS_REQ    = (state == ST_BUSY);
    assign EJ_DMADONE = (state == ST_DONE) && (BUS_OWNER_R == OWN_DMA);
    assign CPU_ACK    = (state == ST_DONE) && (BUS_OWNER_R == OWN_CPU);
    assign EJ_DMAERR  = (state == ST_ERR)  && (BUS_OWNER_R == OWN_DMA);
    assign CPU_ERR    = (state == ST_ERR)  && (BUS_OWNER_R == OWN_CPU);

endmodule
